// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl: sole owner of the register file write port. Merges
// in-order pipeline writebacks with buffered M-unit results and keeps the
// busy scoreboard that decode uses to stall on outstanding M-results.
module rf_writeback_ctrl #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_rd,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        busy_any,
    output logic        rf_we,
    output logic [4:0]  rf_rd_addr,
    output logic [31:0] rf_rd_data
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } md_entry_t;

    md_entry_t        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             src_md;
    logic [31:0]      busy;
    logic [31:0]      busy_nxt;
    md_entry_t        head;

    logic wb_go;
    logic md_push;
    logic md_pop;

    // Write-port arbitration and FIFO handshake decode
    assign wb_go    = wb_valid && (wb_rd != 5'd0);
    assign md_ready = !rst && (count < CNT_W'(FIFO_DEPTH));
    assign md_push  = md_valid && md_ready && (md_rd != 5'd0);
    assign md_pop   = !wb_go && (count != CNT_W'(0));
    assign head     = fifo_mem[rd_ptr];

    // Scoreboard views for decode; reflect state as of the last edge
    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];
    assign busy_any = |busy;

    // Next scoreboard: commit of an M-result clears, issue sets (set wins)
    always_comb begin
        busy_nxt = busy;
        if (rf_we && src_md) begin
            busy_nxt[rf_rd_addr] = 1'b0;
        end
        if (md_issue && (md_issue_rd != 5'd0)) begin
            busy_nxt[md_issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // M-result buffer storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (md_push) begin
            fifo_mem[wr_ptr] <= md_entry_t'{rd: md_rd, data: md_data};
        end
    end

    // M-result buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (md_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (md_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (md_push && !md_pop) begin
                count <= count + CNT_W'(1);
            end else if (!md_push && md_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Registered write port: pipeline first, then FIFO head, else idle hold
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_rd_addr <= 5'd0;
            rf_rd_data <= 32'd0;
            src_md     <= 1'b0;
        end else if (wb_go) begin
            rf_we      <= 1'b1;
            rf_rd_addr <= wb_rd;
            rf_rd_data <= wb_data;
            src_md     <= 1'b0;
        end else if (md_pop) begin
            rf_we      <= 1'b1;
            rf_rd_addr <= head.rd;
            rf_rd_data <= head.data;
            src_md     <= 1'b1;
        end else begin
            rf_we      <= 1'b0;
            src_md     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: directed per-cycle vector table with constant
// expectations, a write-order scoreboard driven by a small behavioural model,
// and a randomised traffic phase checked by the same scoreboard.
module tb_rf_writeback_ctrl;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        busy_any;
    logic        rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;

    always #5 clk = ~clk;

    rf_writeback_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .md_issue(md_issue), .md_issue_rd(md_issue_rd),
        .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .busy_any(busy_any),
        .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data)
    );

    typedef struct {
        logic        rst;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        iss;
        logic [4:0]  issrd;
        logic        mdv;
        logic [4:0]  mdrd;
        logic [31:0] mdd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_rdy;
        logic        e_b1;
        logic        e_b2;
        logic        e_any;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [4:0]  mq_rd [$];
    logic [31:0] mq_d  [$];
    logic [4:0]  exp_a [$];
    logic [31:0] exp_d [$];
    logic [31:0] busy_m;
    logic        pend_clr;
    logic [4:0]  pend_rd;
    logic        exp_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int r, input int wbv, input int wbrd, input logic [31:0] wbd,
                                input int iss, input int issrd, input int mdv, input int mdrd,
                                input logic [31:0] mdd, input int rs1, input int rs2,
                                input int e_we, input int e_addr, input logic [31:0] e_data,
                                input int e_rdy, input int e_b1, input int e_b2, input int e_any);
        vec_t v;
        v.rst = 1'(r);     v.wbv = 1'(wbv);   v.wbrd = 5'(wbrd);   v.wbd = wbd;
        v.iss = 1'(iss);   v.issrd = 5'(issrd);
        v.mdv = 1'(mdv);   v.mdrd = 5'(mdrd); v.mdd = mdd;
        v.rs1 = 5'(rs1);   v.rs2 = 5'(rs2);
        v.e_we = 1'(e_we); v.e_addr = 5'(e_addr); v.e_data = e_data;
        v.e_rdy = 1'(e_rdy); v.e_b1 = 1'(e_b1); v.e_b2 = 1'(e_b2); v.e_any = 1'(e_any);
        return v;
    endfunction

    // One clock cycle: check registered outputs, drive inputs, check
    // combinational outputs, advance the model, then take the edge.
    task automatic do_cycle(input vec_t v, input bit chk, input string tag);
        logic model_ready;
        logic wbgo;
        logic [31:0] nb;
        check({tag, " rf_we vs model"}, 32'(rf_we), 32'(exp_we));
        if (rf_we === 1'b1) begin
            if (exp_a.size() == 0) begin
                check({tag, " unexpected write addr"}, 32'(rf_rd_addr), 32'hFFFF_FFFF);
            end else begin
                check({tag, " write addr order"}, 32'(rf_rd_addr), 32'(exp_a.pop_front()));
                check({tag, " write data order"}, rf_rd_data, exp_d.pop_front());
            end
        end
        if (chk) begin
            check({tag, " rf_we"}, 32'(rf_we), 32'(v.e_we));
            check({tag, " rf_rd_addr"}, 32'(rf_rd_addr), 32'(v.e_addr));
            check({tag, " rf_rd_data"}, rf_rd_data, v.e_data);
        end

        rst = v.rst;
        wb_valid = v.wbv;    wb_rd = v.wbrd;       wb_data = v.wbd;
        md_issue = v.iss;    md_issue_rd = v.issrd;
        md_valid = v.mdv;    md_rd = v.mdrd;       md_data = v.mdd;
        rs1_addr = v.rs1;    rs2_addr = v.rs2;
        #1;

        model_ready = !v.rst && (mq_rd.size() < DEPTH);
        check({tag, " md_ready vs model"}, 32'(md_ready), 32'(model_ready));
        check({tag, " rs1_busy vs model"}, 32'(rs1_busy), 32'(busy_m[v.rs1]));
        check({tag, " rs2_busy vs model"}, 32'(rs2_busy), 32'(busy_m[v.rs2]));
        check({tag, " busy_any vs model"}, 32'(busy_any), 32'(|busy_m));
        if (chk) begin
            check({tag, " md_ready"}, 32'(md_ready), 32'(v.e_rdy));
            check({tag, " rs1_busy"}, 32'(rs1_busy), 32'(v.e_b1));
            check({tag, " rs2_busy"}, 32'(rs2_busy), 32'(v.e_b2));
            check({tag, " busy_any"}, 32'(busy_any), 32'(v.e_any));
        end

        if (v.rst) begin
            mq_rd.delete(); mq_d.delete(); exp_a.delete(); exp_d.delete();
            busy_m = '0; pend_clr = 1'b0; exp_we = 1'b0;
        end else begin
            nb = busy_m;
            if (pend_clr) nb[pend_rd] = 1'b0;
            if (v.iss && v.issrd != 5'd0) nb[v.issrd] = 1'b1;
            busy_m = nb;
            pend_clr = 1'b0;
            wbgo = v.wbv && (v.wbrd != 5'd0);
            if (wbgo) begin
                exp_a.push_back(v.wbrd); exp_d.push_back(v.wbd); exp_we = 1'b1;
            end else if (mq_rd.size() > 0) begin
                pend_rd = mq_rd.pop_front(); pend_clr = 1'b1;
                exp_a.push_back(pend_rd); exp_d.push_back(mq_d.pop_front()); exp_we = 1'b1;
            end else begin
                exp_we = 1'b0;
            end
            if (v.mdv && model_ready && v.mdrd != 5'd0) begin
                mq_rd.push_back(v.mdrd); mq_d.push_back(v.mdd);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl [$];
        vec_t rv;

        rst = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        md_issue = 1'b0; md_issue_rd = '0; md_valid = 1'b0; md_rd = '0; md_data = '0;
        rs1_addr = '0; rs2_addr = '0;
        busy_m = '0; pend_clr = 1'b0; pend_rd = '0; exp_we = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("reset rf_we", 32'(rf_we), 32'd0);
        check("reset rf_rd_addr", 32'(rf_rd_addr), 32'd0);
        check("reset rf_rd_data", rf_rd_data, 32'd0);
        check("reset md_ready low", 32'(md_ready), 32'd0);
        check("reset busy_any", 32'(busy_any), 32'd0);

        //            rst wbv rd data          iss rd mdv rd data       rs1 rs2  we ad data         rdy b1 b2 any
        tbl.push_back(mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,      0, 0,   0, 0, 32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,      0, 0,   1, 5, 32'hDEADBEEF, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,      0, 0,   0, 5, 32'hDEADBEEF, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 7, 0, 0, 32'h0,      7, 0,   0, 5, 32'hDEADBEEF, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,      7, 0,   0, 5, 32'hDEADBEEF, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,      7, 0,   0, 5, 32'hDEADBEEF, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 7, 32'h12,     7, 0,   0, 5, 32'hDEADBEEF, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,      7, 0,   0, 5, 32'hDEADBEEF, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,      7, 0,   1, 7, 32'h12,       1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,      7, 0,   0, 7, 32'h12,       1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 32'h100,      0, 0, 1, 20, 32'hA0,    0, 0,   0, 7, 32'h12,       1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2, 32'h200,      0, 0, 1, 21, 32'hA1,    0, 0,   1, 1, 32'h100,      1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 32'h300,      0, 0, 1, 22, 32'hA2,    0, 0,   1, 2, 32'h200,      0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,      0, 0,   1, 3, 32'h300,      0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,      0, 0,   1, 20, 32'hA0,      1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,      0, 0,   1, 21, 32'hA1,      1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 32'h33,       0, 0, 1, 4, 32'h44,     0, 0,   0, 21, 32'hA1,      1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,      0, 0,   1, 3, 32'h33,       1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,      0, 0,   1, 4, 32'h44,       1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 6, 32'h66,       0, 0, 1, 11, 32'hB1,    0, 0,   0, 4, 32'h44,       1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 12, 32'hB2,    0, 0,   1, 6, 32'h66,       1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,      0, 0,   1, 11, 32'hB1,      1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,      0, 0,   1, 12, 32'hB2,      1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'hFFFF,     0, 0, 1, 0, 32'hEEEE,   0, 0,   0, 12, 32'hB2,      1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,      0, 0,   0, 12, 32'hB2,      1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 32'h1234,     0, 0, 1, 0, 32'h5678,   0, 0,   0, 12, 32'hB2,      1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 32'h1,        1, 9, 0, 0, 32'h0,      0, 0,   0, 12, 32'hB2,      1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2, 32'h2,        1, 10, 1, 9, 32'h99,    9, 10,  1, 1, 32'h1,        1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 3, 32'h3,        0, 0, 1, 10, 32'h1010,  9, 10,  1, 2, 32'h2,        1, 1, 1, 1));
        tbl.push_back(mk(1, 1, 4, 32'h4,        0, 0, 0, 0, 32'h0,      9, 10,  1, 3, 32'h3,        0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,      9, 10,  0, 0, 32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,      9, 10,  0, 0, 32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,      9, 10,  0, 0, 32'h0,        1, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            do_cycle(tbl[i], 1'b1, $sformatf("row%0d", i));
        end

        // Randomised mixed traffic, checked against the model only
        for (int c = 0; c < 400; c++) begin
            rv = mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
            rv.rst   = ($urandom_range(0, 99) == 0);
            rv.wbv   = ($urandom_range(0, 2) == 0);
            rv.wbrd  = 5'($urandom_range(0, 31));
            rv.wbd   = $urandom;
            rv.iss   = ($urandom_range(0, 3) == 0);
            rv.issrd = 5'($urandom_range(0, 31));
            rv.mdv   = ($urandom_range(0, 1) == 0);
            rv.mdrd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rv.mdd   = $urandom;
            rv.rs1   = 5'($urandom_range(0, 31));
            rv.rs2   = 5'($urandom_range(0, 31));
            do_cycle(rv, 1'b0, $sformatf("rand%0d", c));
        end

        // Drain and confirm every predicted write appeared
        for (int c = 0; c < 6; c++) begin
            rv = mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
            do_cycle(rv, 1'b0, $sformatf("drain%0d", c));
        end
        check("pending writes after drain", 32'(exp_a.size()), 32'd0);
        check("busy_any after drain", 32'(busy_any), 32'(|busy_m));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
